pmem_line_model: RTL and testbench
==================================

# pmem_line_model

Parametrised, synthesizable line-granular physical memory responder for the mp3 system bench and for FPGA bring-up. It sits on the pmem side of the cache hierarchy and answers the pmem read/write/resp handshake. Line width, depth and response latency are configurable. It adds protocol checking (simultaneous read+write, out-of-range address), abort on request withdrawal, and access counters.

## Interface
- LINE_BITS, 256, line width in bits; power of two, ≥ 32
- ADDR_BITS, 32, byte-address width
- DEPTH_LINES, 512, number of lines stored; power of two
- LATENCY, 4, cycles from request acceptance to resp; ≥ 1
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- read  input  1  line read request, held until resp
- write  input  1  line write request, held until resp
- address  input  ADDR_BITS  byte address; low log2(LINE_BITS/8) bits ignored
- wdata  input  LINE_BITS  write line
- resp  output  1  one-cycle completion pulse
- rdata  output  LINE_BITS  read line, registered
- err_both  output  1  sticky: read and write seen together at acceptance
- err_oor  output  1  sticky: accepted address above DEPTH_LINES range
- rd_count  output  32  completed reads
- wr_count  output  32  completed writes

## Operation
- OFF = log2(LINE_BITS/8), IDX = log2(DEPTH_LINES); index = address[OFF +: IDX].
- Acceptance occurs only in IDLE on an edge where read or write is high. At acceptance the block latches index, op and wdata. Later changes to address or wdata have no effect.
- read and write both high at acceptance: err_both is set and the request is handled as a read. The write is dropped.
- Any address bit at or above OFF+IDX is set at acceptance: err_oor is set. The access still proceeds on the wrapped index (modulo DEPTH_LINES).
- Abort: if the accepted op's request line (read for reads, write for writes) is low on any BUSY edge, the block returns to IDLE. No resp, no write commit, no counter change.
- States:
  - IDLE → BUSY on acceptance.
  - BUSY → RESP when cnt == 0; otherwise cnt decrements.
  - RESP → IDLE unconditionally. The request still visible at that edge is not re-accepted.
- Write commits into storage on the edge entering RESP. Read data is loaded into rdata on the same edge. rdata holds until the next completed read.
- Storage contents are not reset. An unwritten line reads as undefined (X in simulation).
- Counters increment on the edge entering RESP and wrap at 2^32.

## Timing
- Acceptance edge k loads cnt = LATENCY−1. resp is high for exactly one cycle, starting at edge k+LATENCY.
- Minimum request-to-request spacing is LATENCY+2 edges: accept, LATENCY, plus one IDLE edge.
- rdata is valid in the same cycle resp is high.
- Reset values: state IDLE, cnt 0, resp 0, rdata 0, err_both 0, err_oor 0, rd_count 0, wr_count 0.
- rst during BUSY or RESP returns to IDLE next edge. A pending write does not commit and resp is not raised. Storage is unaffected.
- rst has priority over all other inputs.

## Structure
- Package pmem_model_pkg holds:
  - state enum pmem_state_t {IDLE, BUSY, RESP};
  - function clog2-based OFF/IDX helpers;
  - counter width constant CNT_W = 32.
- Sub-module line_ram holds the DEPTH_LINES × LINE_BITS array.
  - One synchronous write port and one synchronous read port, with no reset.
  - It is instantiated once.
- The top module holds the FSM, latency counter, request latches, error flags and counters.

## Test plan
- Write 0xA5…A5 to 0x0000_0040, then read 0x0000_0040 (LATENCY=4). Expected: resp at acceptance+4 for each access, rdata = 0xA5…A5, wr_count=1, rd_count=1.
- Read 0x0000_005F (same line as 0x40, offset bits ignored). Expected: rdata = 0xA5…A5.
- read and write both high, address 0x80, wdata 0xFF…FF. Expected: err_both=1, resp after 4 cycles, line 0x80 unchanged, rd_count increments, wr_count unchanged.
- Address 0x0000_4040 with DEPTH_LINES=512, LINE_BITS=256 (range 16 KiB). Expected: err_oor=1, access aliases to line of 0x40.
- Write request dropped after 2 BUSY cycles. Expected: no resp, memory unchanged, wr_count unchanged, next request accepted normally.
- rst asserted one cycle before resp of a pending write. Expected: all outputs at reset values, target line unchanged on a later read.

Source files
------------

// File: rtl/pmem_model_pkg.sv
// Shared types and sizing helpers for the line-granular pmem responder.
package pmem_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  localparam int CNT_W = 32;

  // Byte-offset bits within one line.
  function automatic int off_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int idx_bits(input int depth_lines);
    return $clog2(depth_lines);
  endfunction

endpackage

// File: rtl/pmem_line_model_line_ram.sv
// Line storage: one synchronous write port, one registered read port, no reset.
module line_ram #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/pmem_line_model.sv
// Line-granular physical memory responder: fixed-latency read/write handshake
// with abort on request withdrawal, sticky protocol error flags and access counters.
module pmem_line_model
  import pmem_model_pkg::*;
#(
  parameter int LINE_BITS   = 256,
  parameter int ADDR_BITS   = 32,
  parameter int DEPTH_LINES = 512,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [LINE_BITS-1:0] wdata,
  output logic                 resp,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 err_both,
  output logic                 err_oor,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count
);

  localparam int OFF = off_bits(LINE_BITS);
  localparam int IDX = idx_bits(DEPTH_LINES);
  localparam int HI  = OFF + IDX;
  localparam int LW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  pmem_state_t          state_reg;
  logic [LW-1:0]        cnt_reg;
  logic [IDX-1:0]       idx_reg;
  logic                 op_write_reg;
  logic [LINE_BITS-1:0] wdata_reg;
  logic                 resp_reg;
  logic                 err_both_reg;
  logic                 err_oor_reg;
  logic                 rd_valid_reg;
  logic [CNT_W-1:0]     rd_count_reg;
  logic [CNT_W-1:0]     wr_count_reg;

  logic                 req_held;
  logic                 oor;
  logic                 commit;
  logic [LINE_BITS-1:0] ram_rdata;

  assign req_held = op_write_reg ? write : read;
  assign oor      = (HI < ADDR_BITS) ? |(address >> HI) : 1'b0;

  // The RAM has no reset, so reset must explicitly block the final commit.
  assign commit = !rst && (state_reg == BUSY) && req_held && (cnt_reg == '0);

  line_ram #(
    .WIDTH(LINE_BITS),
    .DEPTH(DEPTH_LINES),
    .AW   (IDX)
  ) u_line_ram (
    .clk  (clk),
    .we   (commit && op_write_reg),
    .waddr(idx_reg),
    .wdata(wdata_reg),
    .re   (commit && !op_write_reg),
    .raddr(idx_reg),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      op_write_reg <= 1'b0;
      wdata_reg    <= '0;
      resp_reg     <= 1'b0;
      err_both_reg <= 1'b0;
      err_oor_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      resp_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (read || write) begin
            state_reg    <= BUSY;
            cnt_reg      <= LW'(LATENCY - 1);
            idx_reg      <= address[OFF +: IDX];
            op_write_reg <= write && !read;
            wdata_reg    <= wdata;
            if (read && write) err_both_reg <= 1'b1;
            if (oor) err_oor_reg <= 1'b1;
          end
        end
        BUSY: begin
          if (!req_held) begin
            state_reg <= IDLE;
          end else if (cnt_reg == '0) begin
            state_reg <= RESP;
            resp_reg  <= 1'b1;
            if (op_write_reg) begin
              wr_count_reg <= wr_count_reg + CNT_W'(1);
            end else begin
              rd_count_reg <= rd_count_reg + CNT_W'(1);
              rd_valid_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The RAM read register only loads on completed reads, so it already holds
  // the last read line; before any read since reset the output is forced to 0.
  assign rdata    = rd_valid_reg ? ram_rdata : '0;
  assign resp     = resp_reg;
  assign err_both = err_both_reg;
  assign err_oor  = err_oor_reg;
  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_pmem_line_model.sv
// Directed bench for pmem_line_model at default parameters (256-bit lines, 512 lines, latency 4).
module tb_pmem_line_model;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  address = '0;
  logic [255:0] wdata = '0;
  logic         resp;
  logic [255:0] rdata;
  logic         err_both;
  logic         err_oor;
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] PA5 = {32{8'hA5}};
  localparam logic [255:0] PC3 = {32{8'hC3}};
  localparam logic [255:0] P0F = {32{8'h0F}};
  localparam logic [255:0] PFF = {32{8'hFF}};

  pmem_line_model dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .address (address),
    .wdata   (wdata),
    .resp    (resp),
    .rdata   (rdata),
    .err_both(err_both),
    .err_oor (err_oor),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Called at a negedge; returns edges from acceptance to the first resp (-1 on timeout).
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] data, output int lat);
    read = rd; write = wr; address = addr; wdata = data;
    lat = -1;
    for (int j = 0; j <= 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp) begin
        lat = j;
        break;
      end
    end
    read = 1'b0; write = 1'b0;
    address = 32'hFFFF_FFC0;  // must not disturb the completed access
    @(posedge clk);
    @(negedge clk);
    check("resp_one_cycle", {255'd0, resp}, 256'd0);
  endtask

  task automatic count_resps(input int cycles, output int n);
    n = 0;
    for (int j = 0; j < cycles; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp) n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp"},     {255'd0, resp}, 256'd0);
    check({tag, "_rdata"},    rdata, 256'd0);
    check({tag, "_err_both"}, {255'd0, err_both}, 256'd0);
    check({tag, "_err_oor"},  {255'd0, err_oor}, 256'd0);
    check({tag, "_rd_count"}, {224'd0, rd_count}, 256'd0);
    check({tag, "_wr_count"}, {224'd0, wr_count}, 256'd0);
  endtask

  initial begin
    int lat;
    int n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    access(1'b0, 1'b1, 32'h0000_0040, PA5, lat);
    check("wr40_latency", 256'(lat), 256'd4);
    check("wr40_wr_count", {224'd0, wr_count}, 256'd1);

    access(1'b1, 1'b0, 32'h0000_0040, '0, lat);
    check("rd40_latency", 256'(lat), 256'd4);
    check("rd40_rdata", rdata, PA5);
    check("rd40_rd_count", {224'd0, rd_count}, 256'd1);

    access(1'b1, 1'b0, 32'h0000_005F, '0, lat);
    check("rd5F_rdata", rdata, PA5);

    access(1'b0, 1'b1, 32'h0000_0080, PC3, lat);
    check("wr80_wr_count", {224'd0, wr_count}, 256'd2);
    check("pre_both_err_both", {255'd0, err_both}, 256'd0);

    access(1'b1, 1'b1, 32'h0000_0080, PFF, lat);
    check("both_latency", 256'(lat), 256'd4);
    check("both_err_both", {255'd0, err_both}, 256'd1);
    check("both_rdata", rdata, PC3);
    check("both_rd_count", {224'd0, rd_count}, 256'd3);
    check("both_wr_count", {224'd0, wr_count}, 256'd2);

    access(1'b1, 1'b0, 32'h0000_0080, '0, lat);
    check("rd80_unchanged", rdata, PC3);
    check("pre_oor_err_oor", {255'd0, err_oor}, 256'd0);

    access(1'b1, 1'b0, 32'h0000_4040, '0, lat);
    check("oor_err_oor", {255'd0, err_oor}, 256'd1);
    check("oor_alias_rdata", rdata, PA5);
    check("oor_rd_count", {224'd0, rd_count}, 256'd5);

    // Write withdrawn after two BUSY edges.
    write = 1'b1; address = 32'h0000_0040; wdata = P0F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    write = 1'b0;
    count_resps(8, n);
    check("abort_no_resp", 256'(n), 256'd0);
    check("abort_wr_count", {224'd0, wr_count}, 256'd2);
    access(1'b1, 1'b0, 32'h0000_0040, '0, lat);
    check("abort_next_latency", 256'(lat), 256'd4);
    check("abort_mem_unchanged", rdata, PA5);

    // Reset sampled one edge before the resp of a pending write.
    write = 1'b1; address = 32'h0000_0040; wdata = P0F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_busy");
    rst = 1'b0; write = 1'b0;
    count_resps(6, n);
    check("rst_no_resp", 256'(n), 256'd0);
    access(1'b1, 1'b0, 32'h0000_0040, '0, lat);
    check("rst_mem_unchanged", rdata, PA5);
    check("rst_rd_count", {224'd0, rd_count}, 256'd1);
    check("rst_wr_count", {224'd0, wr_count}, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
